// File: rtl/split_sched_pkg.sv
// Shared types and constants for the split-constraint sampler.
package split_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_EVAL = 2'd2,
    S_RESP = 2'd3
  } sampler_state_e;

  // Default Galois feedback mask and reset seed (lower VEC_W bits are used).
  localparam logic [63:0] DEF_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEF_SEED = 64'h1;

  // Width needed to count 0..max_tries inclusive.
  function automatic int tries_w(input int max_tries);
    return (max_tries < 1) ? 1 : $clog2(max_tries + 1);
  endfunction

endpackage

// File: rtl/split_lfsr.sv
// Right-shifting Galois LFSR with zero-state exclusion on reset, load and step.
module split_lfsr
  import split_sched_pkg::*;
#(
  parameter int               VEC_W = 64,
  parameter logic [VEC_W-1:0] TAPS  = VEC_W'(DEF_TAPS),
  parameter logic [VEC_W-1:0] SEED  = VEC_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [VEC_W-1:0] load_val,
  input  logic             step,
  output logic [VEC_W-1:0] state
);

  localparam logic [VEC_W-1:0] ONE     = VEC_W'(1);
  localparam logic [VEC_W-1:0] SEED_NZ = (SEED == '0) ? ONE : SEED;

  logic [VEC_W-1:0] nxt;
  logic [VEC_W-1:0] load_nz;

  // One Galois step; a zero result can only arise from a bad mask, so guard it anyway.
  always_comb begin
    nxt = (state >> 1) ^ (state[0] ? TAPS : '0);
    if (nxt == '0) nxt = ONE;
    load_nz = (load_val == '0) ? ONE : load_val;
  end

  // State register: load wins over step; zero is never stored.
  always_ff @(posedge clk) begin
    if (rst)       state <= SEED_NZ;
    else if (load) state <= load_nz;
    else if (step) state <= nxt;
  end

endmodule

// File: rtl/split_sampler_ctrl.sv
// Drives LFSR candidates into the split checkers until all enabled ones accept,
// or the try budget runs out, then holds the result for a valid/ready handoff.
module split_sampler_ctrl
  import split_sched_pkg::*;
#(
  parameter int          NUM_SPLITS = 4,
  parameter int          VEC_W      = 64,
  parameter int          MAX_TRIES  = 1024,
  parameter logic [63:0] SEED       = DEF_SEED,
  parameter logic [63:0] TAPS       = DEF_TAPS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          seed_load_i,
  input  logic [VEC_W-1:0]              seed_i,
  input  logic [NUM_SPLITS-1:0]         split_en_i,
  input  logic [NUM_SPLITS-1:0]         split_ok_i,
  output logic [VEC_W-1:0]              cand_o,
  output logic                          busy_o,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic                          res_fail_o,
  output logic [tries_w(MAX_TRIES)-1:0] tries_o
);

  localparam int          TW        = tries_w(MAX_TRIES);
  localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);

  sampler_state_e          state_q, state_d;
  logic [NUM_SPLITS-1:0]   en_q;
  logic [VEC_W-1:0]        cand_q;
  logic [TW-1:0]           tries_q;
  logic                    fail_q;

  logic [VEC_W-1:0]        lfsr_state;
  logic                    lfsr_load;
  logic                    lfsr_step;
  logic                    begin_req;
  logic                    do_gen;
  logic                    set_res;
  logic                    fail_d;
  logic                    pass;

  // The LFSR is stepped on the edge that enters GEN, so its advanced state is
  // already present during GEN and lands in cand_q on the edge leaving GEN.
  split_lfsr #(
    .VEC_W (VEC_W),
    .TAPS  (VEC_W'(TAPS)),
    .SEED  (VEC_W'(SEED))
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed_i),
    .step     (lfsr_step),
    .state    (lfsr_state)
  );

  assign pass = &(split_ok_i | ~en_q);

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    begin_req = 1'b0;
    do_gen    = 1'b0;
    set_res   = 1'b0;
    fail_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // start wins; a same-cycle seed load is dropped
          state_d   = S_GEN;
          begin_req = 1'b1;
          lfsr_step = 1'b1;
        end else if (seed_load_i) begin
          lfsr_load = 1'b1;
        end
      end
      S_GEN: begin
        do_gen  = 1'b1;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (pass) begin
          state_d = S_RESP;
          set_res = 1'b1;
          fail_d  = 1'b0;
        end else if (tries_q == TRIES_MAX) begin
          state_d = S_RESP;
          set_res = 1'b1;
          fail_d  = 1'b1;
        end else begin
          state_d   = S_GEN;
          lfsr_step = 1'b1;
        end
      end
      S_RESP: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Request datapath: enable capture, candidate register, try counter, fail flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= '0;
      cand_q  <= '0;
      tries_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      if (begin_req) begin
        en_q    <= split_en_i;
        tries_q <= '0;
        fail_q  <= 1'b0;
      end
      if (do_gen) begin
        cand_q <= lfsr_state;
        if (tries_q != TRIES_MAX) tries_q <= tries_q + 1'b1;
      end
      if (set_res) fail_q <= fail_d;
    end
  end

  assign cand_o      = cand_q;
  assign tries_o     = tries_q;
  assign res_fail_o  = fail_q;
  assign busy_o      = (state_q != S_IDLE);
  assign res_valid_o = (state_q == S_RESP);

endmodule

// File: tb/tb_split_sampler_ctrl.sv
// Directed bench for split_sampler_ctrl with a queue-based scoreboard.
module tb_split_sampler_ctrl;

  localparam int          NS   = 4;
  localparam int          VW   = 64;
  localparam int          MT   = 8;
  localparam int          TW   = $clog2(MT + 1);
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          seed_load = 1'b0;
  logic [VW-1:0] seed = '0;
  logic [NS-1:0] en = '0;
  logic [NS-1:0] ok;
  logic [VW-1:0] cand;
  logic          busy, valid, fail, ready;
  logic [TW-1:0] tries;

  int mode = 0;   // 0: every candidate ok, 1: never ok, 2: ok only when cand[3:0]==A
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] cand;
    int          tries;
    logic        fail;
    int          t0;
  } exp_t;

  exp_t        q[$];
  logic [63:0] m_lfsr = 64'h1;

  split_sampler_ctrl #(
    .NUM_SPLITS (NS),
    .VEC_W      (VW),
    .MAX_TRIES  (MT),
    .SEED       (64'h1),
    .TAPS       (TAPS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .seed_load_i (seed_load),
    .seed_i      (seed),
    .split_en_i  (en),
    .split_ok_i  (ok),
    .cand_o      (cand),
    .busy_o      (busy),
    .res_valid_o (valid),
    .res_ready_i (ready),
    .res_fail_o  (fail),
    .tries_o     (tries)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Checker stub
  always_comb begin
    ok = '0;
    case (mode)
      0:       ok = '1;
      2:       ok = (cand[3:0] == 4'hA) ? '1 : '0;
      default: ok = '0;
    endcase
  end

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    logic [63:0] n;
    n = (s >> 1) ^ (s[0] ? TAPS : 64'h0);
    if (n == 64'h0) n = 64'h1;
    return n;
  endfunction

  function automatic logic ok_model(input logic [63:0] c, input int md);
    if (md == 0) return 1'b1;
    if (md == 2) return (c[3:0] == 4'hA);
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Golden model of one request; advances m_lfsr and queues the expected result.
  task automatic push_exp(input logic [NS-1:0] en_v, input int md);
    exp_t e;
    logic pass;
    e.fail = 1'b0;
    e.tries = 0;
    e.t0 = cyc;
    for (int t = 1; t <= MT; t++) begin
      m_lfsr  = lfsr_next(m_lfsr);
      e.cand  = m_lfsr;
      e.tries = t;
      pass = (en_v == '0) ? 1'b1 : ok_model(m_lfsr, md);
      if (pass) break;
      if (t == MT) e.fail = 1'b1;
    end
    q.push_back(e);
  endtask

  // Issue one request, optionally with a same-cycle seed load or a held start,
  // then accept the result after 'hold' stall cycles.
  task automatic request(input logic [NS-1:0] en_v, input int md, input int hold,
                         input bit sl, input logic [63:0] sv, input bit start_hold);
    int k;
    @(negedge clk);
    en = en_v; mode = md; start = 1'b1;
    if (sl) begin seed_load = 1'b1; seed = sv; end
    push_exp(en_v, md);
    if (!start_hold) begin
      @(negedge clk);
      start = 1'b0; seed_load = 1'b0;
    end
    k = 0;
    while (!valid && k < 100) begin @(negedge clk); k++; end
    start = 1'b0;
    if (!valid) begin
      checks++; errors++;
      $display("FAIL timeout waiting for res_valid_o");
    end
    repeat (hold) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic load_seed(input logic [63:0] sv);
    @(negedge clk);
    seed = sv; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr = (sv == 64'h0) ? 64'h1 : sv;
  endtask

  // Monitor: pop on the rising edge of valid, then require a stable result while held.
  logic        prev_v = 1'b0;
  logic [63:0] h_cand = '0;
  logic [TW-1:0] h_tries = '0;
  logic        h_fail = 1'b0;
  always @(negedge clk) begin
    exp_t cur;
    if (valid && !prev_v) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result cand %h tries %0d", cand, tries);
      end else begin
        cur = q.pop_front();
        check("cand", cand, cur.cand);
        check("tries", 64'(tries), 64'(cur.tries));
        check("fail", 64'(fail), 64'(cur.fail));
        check("latency", 64'(cyc - cur.t0), 64'(2 * cur.tries + 1));
      end
    end else if (valid) begin
      check("hold_cand", cand, h_cand);
      check("hold_tries", 64'(tries), 64'(h_tries));
      check("hold_fail", 64'(fail), 64'(h_fail));
    end
    prev_v  <= valid;
    h_cand  <= cand;
    h_tries <= tries;
    h_fail  <= fail;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cand"},  cand, 64'h0);
    check({tag, "_busy"},  64'(busy), 64'h0);
    check({tag, "_valid"}, 64'(valid), 64'h0);
    check({tag, "_fail"},  64'(fail), 64'h0);
    check({tag, "_tries"}, 64'(tries), 64'h0);
  endtask

  initial begin
    ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst");

    // First-try pass from the reset seed
    request(4'b1111, 0, 0, 1'b0, 64'h0, 1'b0);
    // Searched pass: seed 0x50 reaches low nibble A on the third step; stall 5 cycles
    load_seed(64'h50);
    request(4'b1111, 2, 5, 1'b0, 64'h0, 1'b0);
    // Exhaust the try budget
    request(4'b1111, 1, 0, 1'b0, 64'h0, 1'b0);
    // Nothing enabled: first candidate passes even though every checker rejects
    request(4'b0000, 1, 0, 1'b0, 64'h0, 1'b0);
    // Zero seed is stored as 1
    load_seed(64'h0);
    request(4'b1111, 0, 0, 1'b0, 64'h0, 1'b0);
    // Seed load in the start cycle is dropped
    request(4'b1111, 0, 1, 1'b1, 64'h50, 1'b0);
    // start held for the whole request still yields one result
    request(4'b1111, 0, 0, 1'b0, 64'h0, 1'b1);
    repeat (10) @(negedge clk);
    check("busy_after_held_start", 64'(busy), 64'h0);

    // Reset during EVAL aborts with no result
    @(negedge clk);
    en = 4'b1111; mode = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    m_lfsr = 64'h1;
    request(4'b1111, 0, 0, 1'b0, 64'h0, 1'b0);

    repeat (5) @(negedge clk);
    check("pending_results", 64'(q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
